argmax_frame_sched: RTL and testbench

- Sequencer for the argmax classifier stage, sitting between the FC-layer logit buffer (1-cycle-latency read port) and the argmax unit.
- Per frame it clears and arms the argmax unit and streams IN_SIZE logits from the buffer with indices.
- It then waits for the class result (with watchdog) and holds it on a valid/ready result port for the host.
- It releases the logit buffer back to the FC layer via a frame_ack pulse.

---
 rtl/cnn_pkg.sv | 17 +
 rtl/argmax_sched_wdog.sv | 34 +++
 rtl/argmax_frame_sched.sv | 144 ++++++++++++++
 tb/tb_argmax_frame_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared types and defaults for the argmax classifier stage
package cnn_pkg;

  localparam int ACC_WIDTH_DEF = 24;
  localparam int IN_SIZE_DEF   = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_START,
    S_FETCH,
    S_DRAIN,
    S_WAIT,
    S_HOLD
  } sched_state_e;

endpackage

// File: rtl/argmax_sched_wdog.sv
// rtl/argmax_sched_wdog.sv - up-counter with clear; tc_o flags the increment that reaches TIMEOUT
module argmax_sched_wdog #(
  parameter  int TIMEOUT = 16,
  localparam int CW      = $clog2(TIMEOUT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tc_o = en_i && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CW'(TIMEOUT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/argmax_frame_sched.sv
// rtl/argmax_frame_sched.sv - frame sequencer between the logit buffer and the argmax unit
// Optional ARGMAX_SCHED_STATS_EN adds frame_cnt/err_cnt outputs.
module argmax_frame_sched
  import cnn_pkg::*;
#(
  parameter  int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter  int IN_SIZE   = IN_SIZE_DEF,
  parameter  int TIMEOUT   = 16,
  localparam int IDX_W     = $clog2(IN_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_req,
  output logic                 frame_ack,
  output logic                 mem_rd_en,
  output logic [IDX_W-1:0]     mem_rd_addr,
  input  logic [ACC_WIDTH-1:0] mem_rd_data,
  output logic                 am_clr,
  output logic                 am_start,
  output logic                 am_valid,
  output logic                 am_ready,
  output logic [ACC_WIDTH-1:0] am_logit,
  output logic [IDX_W-1:0]     am_idx,
  input  logic                 am_done,
  input  logic [IDX_W-1:0]     am_class,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [IDX_W-1:0]     res_class,
  output logic                 res_err,
  output logic                 busy
`ifdef ARGMAX_SCHED_STATS_EN
  ,
  output logic [15:0]          frame_cnt,
  output logic [7:0]           err_cnt
`endif
);

  localparam logic [IDX_W-1:0] LAST_ADDR = IDX_W'(IN_SIZE - 1);

  sched_state_e     state_q, state_d;
  logic [IDX_W-1:0] addr_q, addr_d;
  logic [IDX_W-1:0] am_idx_q;
  logic             am_valid_q;
  logic [IDX_W-1:0] res_class_q, res_class_d;
  logic             res_err_q, res_err_d;
  logic             wd_tc;

  argmax_sched_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk   (clk),
    .reset (reset),
    .clr_i (state_q == S_DRAIN),
    .en_i  (state_q == S_WAIT),
    .tc_o  (wd_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    res_class_d = res_class_q;
    res_err_d   = res_err_q;
    case (state_q)
      S_IDLE:  if (frame_req) state_d = S_CLR;
      S_CLR:   state_d = S_START;
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        // addr returns to 0 so mem_rd_addr/am_idx idle at zero between frames
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_q + IDX_W'(1);
        end
      end
      S_DRAIN: state_d = S_WAIT;
      S_WAIT: begin
        if (am_done) begin
          res_class_d = am_class;
          res_err_d   = 1'b0;
          state_d     = S_HOLD;
        end else if (wd_tc) begin
          res_class_d = '0;
          res_err_d   = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD:  if (res_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      am_idx_q    <= '0;
      am_valid_q  <= 1'b0;
      res_class_q <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      am_idx_q    <= addr_q;
      am_valid_q  <= (state_q == S_FETCH);
      res_class_q <= res_class_d;
      res_err_q   <= res_err_d;
    end
  end

  assign frame_ack   = (state_q == S_DRAIN);
  assign mem_rd_en   = (state_q == S_FETCH);
  assign mem_rd_addr = addr_q;
  assign am_clr      = (state_q == S_CLR);
  assign am_start    = (state_q == S_START);
  assign am_valid    = am_valid_q;
  assign am_ready    = am_valid_q;
  assign am_logit    = am_valid_q ? mem_rd_data : '0;
  assign am_idx      = am_idx_q;
  assign res_valid   = (state_q == S_HOLD);
  assign res_class   = res_class_q;
  assign res_err     = res_err_q;
  assign busy        = (state_q != S_IDLE);

`ifdef ARGMAX_SCHED_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [7:0]  err_cnt_q;
  logic        res_hs;

  assign res_hs = (state_q == S_HOLD) && res_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else if (res_hs) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
      if (res_err_q && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_argmax_frame_sched.sv
// tb/tb_argmax_frame_sched.sv - scoreboard bench with buffer and argmax-unit models
module tb_argmax_frame_sched;

  localparam int ACC = 24;
  localparam int N   = 10;
  localparam int TO  = 16;
  localparam int IW  = $clog2(N);
  localparam logic signed [ACC-1:0] MINV = {1'b1, {(ACC-1){1'b0}}};

  logic clk = 1'b0, reset = 1'b0, frame_req = 1'b0, res_ready = 1'b1;
  logic frame_ack, mem_rd_en, am_clr, am_start, am_valid, am_ready, am_done;
  logic res_valid, res_err, busy;
  logic [IW-1:0] mem_rd_addr, am_idx, am_class, res_class;
  logic signed [ACC-1:0] mem_rd_data = '0;
  logic signed [ACC-1:0] am_logit;
`ifdef ARGMAX_SCHED_STATS_EN
  logic [15:0] frame_cnt;
  logic [7:0]  err_cnt;
`endif

  int errors = 0, checks = 0, ack_cnt = 0, clr_cnt = 0, exp_idx = 0;
  logic signed [ACC-1:0] mem [N];
  logic [IW:0] sb_q[$];
  bit am_hang = 1'b0;
  logic signed [ACC-1:0] am_max;
  logic am_fin, am_done_q;
  logic [IW-1:0] am_cls;

  argmax_frame_sched #(.ACC_WIDTH(ACC), .IN_SIZE(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_req(frame_req), .frame_ack(frame_ack),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .am_clr(am_clr), .am_start(am_start), .am_valid(am_valid), .am_ready(am_ready),
    .am_logit(am_logit), .am_idx(am_idx), .am_done(am_done), .am_class(am_class),
    .res_valid(res_valid), .res_ready(res_ready), .res_class(res_class),
    .res_err(res_err), .busy(busy)
`ifdef ARGMAX_SCHED_STATS_EN
    , .frame_cnt(frame_cnt), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: lowest index holding the largest logit; timeout yields class 0 with err.
  function automatic logic [IW:0] ref_result(input bit timeout);
    int best = 0;
    if (timeout) return {1'b1, {IW{1'b0}}};
    for (int i = 1; i < N; i++) if (mem[i] > mem[best]) best = i;
    return {1'b0, IW'(best)};
  endfunction

  // Logit buffer: one-cycle read latency.
  always @(posedge clk) begin
    if (mem_rd_en && int'(mem_rd_addr) < N) mem_rd_data <= mem[mem_rd_addr];
  end

  // Argmax unit: strict-greater running max, sticky done two cycles after the last logit.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      am_max <= '0; am_cls <= '0; am_fin <= 1'b0; am_done_q <= 1'b0;
    end else if (am_clr) begin
      am_max <= MINV; am_cls <= '0; am_fin <= 1'b0; am_done_q <= 1'b0;
    end else begin
      if (am_valid) begin
        if (am_logit > am_max) begin
          am_max <= am_logit;
          am_cls <= am_idx;
        end
        if (int'(am_idx) == N - 1) am_fin <= 1'b1;
      end
      if (am_fin && !am_hang) am_done_q <= 1'b1;
    end
  end
  assign am_done  = am_done_q;
  assign am_class = am_cls;

  // Stream monitor: contiguous indices, correct data, ack only after the full frame.
  always @(negedge clk) begin
    if (!reset) begin
      exp_idx = 0;
    end else begin
      if (am_clr) begin
        exp_idx = 0;
        clr_cnt++;
      end
      if (am_valid) begin
        check("am_idx", am_idx, exp_idx);
        check("am_ready", am_ready, am_valid);
        if (exp_idx < N) check("am_logit", am_logit, mem[exp_idx]);
        exp_idx++;
      end
      if (frame_ack) begin
        ack_cnt++;
        check("ack_after_last_logit", exp_idx, N);
      end
    end
  end

  // Result monitor: pops the scoreboard on every handshake.
  always @(negedge clk) begin
    logic [IW:0] exp;
    if (reset && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got class %0d err %0d with empty scoreboard", res_class, res_err);
      end else begin
        exp = sb_q.pop_front();
        check("res_class", res_class, exp[IW-1:0]);
        check("res_err", res_err, exp[IW]);
      end
    end
  end

  task automatic run_frame(input bit hang, input bit rand_ready, input string tag);
    int lat = 0;
    int exp_lat = hang ? 4 + N + TO : 6 + N;
    am_hang = hang;
    ack_cnt = 0;
    sb_q.push_back(ref_result(hang));
    frame_req = 1'b1;
    while (!res_valid && lat < 200) begin
      tick();
      lat++;
      if (am_clr) frame_req = 1'b0;
    end
    frame_req = 1'b0;
    check($sformatf("%s_latency", tag), lat, exp_lat);
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0 && !res_valid) break;
      res_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
    end
    res_ready = 1'b1;
    check($sformatf("%s_drained", tag), sb_q.size(), 0);
    check($sformatf("%s_ack_count", tag), ack_cnt, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int lat;
    for (int i = 0; i < N; i++) mem[i] = '0;
    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_class", res_class, 0);
    check("rst_res_err", res_err, 0);
    check("rst_frame_ack", frame_ack, 0);
    check("rst_mem_rd_en", mem_rd_en, 0);
    check("rst_mem_rd_addr", mem_rd_addr, 0);
    check("rst_am_clr", am_clr, 0);
    check("rst_am_start", am_start, 0);
    check("rst_am_valid", am_valid, 0);
    check("rst_am_logit", am_logit, 0);
    reset = 1'b1;
    tick();

    begin
      int vals[N] = '{5, -3, 90, 7, 90, 0, 1, 2, 3, 4};
      for (int i = 0; i < N; i++) mem[i] = ACC'(vals[i]);
    end
    run_frame(1'b0, 1'b0, "first_max");

    for (int i = 0; i < N; i++) mem[i] = MINV;
    run_frame(1'b0, 1'b0, "all_min");

    for (int i = 0; i < N; i++) mem[i] = ACC'($urandom);
    run_frame(1'b1, 1'b0, "timeout");

    // Result held back while frame_req stays high.
    for (int i = 0; i < N; i++) mem[i] = ACC'($urandom);
    ack_cnt = 0; clr_cnt = 0; am_hang = 1'b0;
    sb_q.push_back(ref_result(1'b0));
    sb_q.push_back(ref_result(1'b0));
    res_ready = 1'b0;
    frame_req = 1'b1;
    lat = 0;
    while (!res_valid && lat < 200) begin tick(); lat++; end
    check("hold_latency", lat, 6 + N);
    repeat (20) begin
      tick();
      check("hold_valid", res_valid, 1);
      check("hold_class", res_class, ref_result(1'b0) & {1'b0, {IW{1'b1}}});
    end
    check("hold_single_clr", clr_cnt, 1);
    res_ready = 1'b1;
    tick();
    check("post_hs_busy", busy, 0);
    check("post_hs_no_clr", am_clr, 0);
    tick();
    check("post_hs_clr", am_clr, 1);
    frame_req = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (sb_q.size() == 0 && !res_valid) break;
      tick();
    end
    check("hold_drained", sb_q.size(), 0);
    check("hold_ack_count", ack_cnt, 2);
    check("hold_clr_count", clr_cnt, 2);

    // Reset in the middle of FETCH.
    for (int i = 0; i < N; i++) mem[i] = ACC'(int'($urandom_range(0, 200)) - 100);
    ack_cnt = 0; am_hang = 1'b0;
    frame_req = 1'b1;
    lat = 0;
    while (!(mem_rd_en && int'(mem_rd_addr) == 4) && lat < 100) begin tick(); lat++; end
    check("abort_at_addr4", mem_rd_addr, 4);
    #2 reset = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_mem_rd_en", mem_rd_en, 0);
    check("abort_mem_rd_addr", mem_rd_addr, 0);
    check("abort_am_valid", am_valid, 0);
    check("abort_frame_ack", frame_ack, 0);
    tick();
    tick();
    check("abort_no_ack", ack_cnt, 0);
    reset = 1'b1;
    run_frame(1'b0, 1'b0, "restart");

    for (int f = 0; f < 8; f++) begin
      for (int i = 0; i < N; i++)
        mem[i] = (f % 2 == 1) ? ACC'($urandom) : ACC'(int'($urandom_range(0, 6)) - 3);
      run_frame(f == 5, 1'b1, $sformatf("rand%0d", f));
    end

`ifdef ARGMAX_SCHED_STATS_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("stats_rst_frame_cnt", frame_cnt, 0);
    check("stats_rst_err_cnt", err_cnt, 0);
    for (int f = 0; f < 5; f++) begin
      for (int i = 0; i < N; i++) mem[i] = ACC'($urandom);
      run_frame(f == 1 || f == 3, 1'b0, $sformatf("stats%0d", f));
    end
    check("stats_frame_cnt", frame_cnt, 5);
    check("stats_err_cnt", err_cnt, 2);
`endif

    check("scoreboard_empty", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
